// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// a width helper that never returns a zero-width vector.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        RELEASE = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } state_t;

    // max(1, $clog2(n)): keeps counters and indices at least one bit wide.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer bus: software request and domain acks in, per-domain
// reset requests and status flags out.
interface rst_seq_ctrl_if #(
    parameter int NUM_DOMAINS = 2
);
    logic                   SW_RST_REQ;
    logic [NUM_DOMAINS-1:0] DOMAIN_ACK;
    logic [NUM_DOMAINS-1:0] DOMAIN_RST_N;
    logic                   RST_BUSY;
    logic                   RST_DONE;
    logic                   RST_TIMEOUT;

    modport master (
        input  SW_RST_REQ,
        input  DOMAIN_ACK,
        output DOMAIN_RST_N,
        output RST_BUSY,
        output RST_DONE,
        output RST_TIMEOUT
    );

    modport slave (
        output SW_RST_REQ,
        output DOMAIN_ACK,
        input  DOMAIN_RST_N,
        input  RST_BUSY,
        input  RST_DONE,
        input  RST_TIMEOUT
    );
endinterface

// File: rtl/rst_seq_ctrl_ack_sync_2ff.sv
// Two-flop synchronizer bank for the per-domain reset-status acks, which
// arrive asynchronously from each destination domain.
module ack_sync_2ff
    import rst_seq_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ack_async,
    output logic [WIDTH-1:0] ack_sync
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= ack_async[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign ack_sync[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases them one at a time
// waiting for each ack. Ack timeout is enabled by RST_SEQ_CTRL_TIMEOUT_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    rst_seq_ctrl_if.master    bus
);

    localparam int IDX_W  = width_of(NUM_DOMAINS);
    localparam int HOLD_W = width_of(HOLD_CYCLES + 1);
    localparam int GAP_W  = width_of(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    generate
        if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("rst_seq_ctrl: illegal parameter value");
        end
    endgenerate

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
    logic [NUM_DOMAINS-1:0] rst_n_reg, rst_n_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic [NUM_DOMAINS-1:0] ack_sync;
    logic                   ack_hit;
    logic                   to_hit;

    ack_sync_2ff #(
        .WIDTH (NUM_DOMAINS)
    ) u_ack_sync (
        .CLK       (CLK),
        .RST       (RST),
        .ack_async (bus.DOMAIN_ACK),
        .ack_sync  (ack_sync)
    );

    // A stale-high ack still counts; the sync depth covers a normal deassert.
    assign ack_hit = ack_sync[idx_reg];

`ifdef RST_SEQ_CTRL_TIMEOUT_EN
    localparam int WAIT_W = width_of(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              timeout_reg, timeout_next;

    assign to_hit          = (wait_cnt_reg == WAIT_LAST);
    assign bus.RST_TIMEOUT = timeout_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end
`else
    assign to_hit          = 1'b0;
    assign bus.RST_TIMEOUT = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ASSERT;
            idx_reg      <= '0;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            rst_n_reg    <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            hold_cnt_reg <= hold_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            rst_n_reg    <= rst_n_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic; a software request overrides everything
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        hold_cnt_next = hold_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
`ifdef RST_SEQ_CTRL_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
`endif
        if (bus.SW_RST_REQ) begin
            state_next    = ASSERT;
            idx_next      = '0;
            hold_cnt_next = '0;
            gap_cnt_next  = '0;
`ifdef RST_SEQ_CTRL_TIMEOUT_EN
            wait_cnt_next = '0;
            timeout_next  = 1'b0;
`endif
        end else begin
            case (state_reg)
                ASSERT: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next    = RELEASE;
                        idx_next      = '0;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (ack_hit || to_hit) begin
`ifdef RST_SEQ_CTRL_TIMEOUT_EN
                        wait_cnt_next = '0;
                        if (!ack_hit) begin
                            timeout_next = 1'b1;
                        end
`endif
                        if (idx_reg == IDX_LAST) begin
                            state_next = DONE;
                        end else if (GAP_CYCLES == 0) begin
                            idx_next = idx_reg + IDX_W'(1);
                        end else begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end else begin
`ifdef RST_SEQ_CTRL_TIMEOUT_EN
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_next   = RELEASE;
                        idx_next     = idx_reg + IDX_W'(1);
                        gap_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                    end
                end
                DONE:    state_next = IDLE;
                IDLE:    state_next = IDLE;
                default: state_next = ASSERT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they can be registered
    always_comb begin
        rst_n_next = '1;
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        case (state_next)
            ASSERT: rst_n_next = '0;
            RELEASE, GAP: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    rst_n_next[i] = (i <= int'(idx_next));
                end
            end
            default: rst_n_next = '1;
        endcase
    end

    assign bus.DOMAIN_RST_N = rst_n_reg;
    assign bus.RST_BUSY     = busy_reg;
    assign bus.RST_DONE     = done_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected output changes,
// a negedge monitor pops and compares each change it observes.
module tb_rst_seq_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    rst_seq_ctrl_if #(.NUM_DOMAINS(2)) bus_if ();

    rst_seq_ctrl #(
        .NUM_DOMAINS    (2),
        .HOLD_CYCLES    (16),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          cyc;
        logic [4:0]  val;   // {DOMAIN_RST_N[1:0], RST_BUSY, RST_DONE, RST_TIMEOUT}
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       mon_en = 1'b0;
    logic [4:0] prev_val = '0;
    logic [1:0] ack_mask = 2'b11;
    logic [1:0] rst_n_prev = 2'b00;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [4:0] cur_val();
        return {bus_if.DOMAIN_RST_N, bus_if.RST_BUSY, bus_if.RST_DONE, bus_if.RST_TIMEOUT};
    endfunction

    // Domain model: each ack echoes its reset request one cycle later.
    initial begin
        bus_if.DOMAIN_ACK = 2'b00;
        forever begin
            @(posedge CLK);
            #2;
            bus_if.DOMAIN_ACK = rst_n_prev & ack_mask;
            rst_n_prev        = bus_if.DOMAIN_RST_N;
        end
    end

    // Monitor: every output change must match the head of the expected queue.
    always @(negedge CLK) begin
        logic [4:0] v;
        exp_t       e;
        if (mon_en) begin
            v = cur_val();
            if (v != prev_val) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, v);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val != v) begin
                        bad++;
                        $display("FAIL %s got cyc=%0d val=%b want cyc=%0d val=%b",
                                 e.name, cyc, v, e.cyc, e.val);
                    end else begin
                        $display("evt %s cyc=%0d rst_n=%b busy=%b done=%b to=%b",
                                 e.name, cyc, v[4:3], v[2], v[1], v[0]);
                    end
                end
                prev_val = v;
            end
        end
    end

    task automatic push(input string n, input int c, input logic [4:0] v);
        exp_t e;
        e.name = n;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string n, input logic [4:0] want);
        logic [4:0] v;
        v = cur_val();
        total++;
        if (v != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", n, cyc, v, want);
        end else begin
            $display("chk %s cyc=%0d val=%b", n, cyc, v);
        end
    endtask

    task automatic wait_drain(input string n);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain got=%0d pending want=0 pending", n, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Called at posedge+1; returns cycle 0 of the new sequence.
    task automatic sw_pulse(output int base);
        bus_if.SW_RST_REQ = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.SW_RST_REQ = 1'b0;
        base = cyc;
    endtask

    // Release/done/idle events of an unobstructed sequence with cycle 0 at b.
    task automatic push_tail(input string n, input int b, input logic to);
        push({n, "_rel0"}, b + 16, {2'b01, 1'b1, 1'b0, to});
        push({n, "_rel1"}, b + 24, {2'b11, 1'b1, 1'b0, to});
        push({n, "_done"}, b + 28, {2'b11, 1'b1, 1'b1, to});
        push({n, "_idle"}, b + 29, {2'b11, 1'b0, 1'b0, to});
    endtask

    initial begin
        int b;
        int b2;
        bus_if.SW_RST_REQ = 1'b0;

        // Power-on
        #1 RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check_now("reset_state", 5'b00_1_0_0);
        prev_val = cur_val();
        mon_en   = 1'b1;
        RST      = 1'b0;
        b        = cyc;
        push_tail("por", b, 1'b0);
        wait_drain("por");

        // Software request from IDLE
        sw_pulse(b);
        push("sw_idle_assert", b, 5'b00_1_0_0);
        push_tail("sw_idle", b, 1'b0);
        wait_drain("sw_idle");

        // Software request during GAP aborts the run without a done pulse
        sw_pulse(b);
        push("gap_assert", b, 5'b00_1_0_0);
        push("gap_rel0", b + 16, 5'b01_1_0_0);
        wait_until(b + 20);
        sw_pulse(b2);
        push("gap_reassert", b2, 5'b00_1_0_0);
        push_tail("gap_rerun", b2, 1'b0);
        wait_drain("gap_abort");

`ifdef RST_SEQ_CTRL_TIMEOUT_EN
        // Domain 0 never acks: timeout after 64 cycles, sequence still completes
        ack_mask = 2'b10;
        sw_pulse(b);
        push("to_assert", b, 5'b00_1_0_0);
        push("to_rel0",   b + 16, 5'b01_1_0_0);
        push("to_flag",   b + 80, 5'b01_1_0_1);
        push("to_rel1",   b + 84, 5'b11_1_0_1);
        push("to_done",   b + 88, 5'b11_1_1_1);
        push("to_idle",   b + 89, 5'b11_0_0_1);
        wait_drain("timeout");
        ack_mask = 2'b11;
        sw_pulse(b);
        push("to_clear", b, 5'b00_1_0_0);
        push_tail("to_rerun", b, 1'b0);
        wait_drain("timeout_clear");
`else
        // Domain 1 never acks: sequence waits indefinitely until it does
        ack_mask = 2'b01;
        sw_pulse(b);
        push("stall_assert", b, 5'b00_1_0_0);
        push("stall_rel0",   b + 16, 5'b01_1_0_0);
        push("stall_rel1",   b + 24, 5'b11_1_0_0);
        wait_drain("stall");
        wait_until(b + 24 + 1000);
        check_now("stall_1000", 5'b11_1_0_0);
        ack_mask = 2'b11;
        b2 = cyc;
        push("stall_done", b2 + 3, 5'b11_1_1_0);
        push("stall_idle", b2 + 4, 5'b11_0_0_0);
        wait_drain("stall_release");
`endif

        // Asynchronous reset in the middle of RELEASE
        sw_pulse(b);
        push("ar_assert", b, 5'b00_1_0_0);
        push("ar_rel0",   b + 16, 5'b01_1_0_0);
        wait_until(b + 18);
        push("ar_async", b + 18, 5'b00_1_0_0);
        #2;
        RST = 1'b1;
        #1;
        check_now("async_reset", 5'b00_1_0_0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        b   = cyc;
        push_tail("ar_rerun", b, 1'b0);
        wait_drain("async_reset");

        repeat (5) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
